// File: rtl/kyber_pkg.sv
// Shared Kyber constants, the reducer tag type and the Montgomery reduction
// arithmetic used by the reducer pipeline.
package kyber_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int KYBER_QINV = -3327;  // q^-1 mod 2^16, signed representative
  localparam int COEF_W     = 16;
  localparam int PROD_W     = 32;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  // Travels alongside an operation through the reducer pipeline so the
  // result can be steered to the response FIFO of the requester that issued it.
  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  // t = (a - sext16((a * QINV) mod 2^16) * Q) >>> 16.
  // The subtraction clears the low 16 bits, so the result is simply the
  // upper half of the 32-bit difference.
  function automatic coef_t mont_reduce_f(input prod_t a);
    logic [COEF_W-1:0] u;
    prod_t             diff;
    u    = COEF_W'(a[COEF_W-1:0] * COEF_W'(KYBER_QINV));
    diff = a - prod_t'($signed(u)) * prod_t'(KYBER_Q);
    return diff[PROD_W-1:COEF_W];
  endfunction

endpackage

// File: rtl/montgomery_reduce.sv
// Enable-gated Montgomery reducer. The first stage captures a new result
// only when set is high; any further stages advance every cycle so the
// result stays aligned with a tag pipe of the same depth. Output t is valid
// LAT clock edges after set is sampled.
module montgomery_reduce
  import kyber_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set,
  input  logic [PROD_W-1:0] a,
  output logic [COEF_W-1:0] t
);

  logic [COEF_W-1:0] stage_q [LAT];
  logic [COEF_W-1:0] stage_d [LAT];

  // Stage 0 loads on set and holds otherwise; later stages shift freely.
  always_comb begin
    stage_d[0] = stage_q[0];
    if (set) begin
      stage_d[0] = mont_reduce_f(a);
    end
    for (int j = 1; j < LAT; j++) begin
      stage_d[j] = stage_q[j-1];
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < LAT; j++) begin
        stage_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < LAT; j++) begin
        stage_q[j] <= stage_d[j];
      end
    end
  end

  assign t = stage_q[LAT-1];

endmodule

// File: rtl/rsp_fifo.sv
// Small synchronous show-ahead FIFO for reducer results. The head entry is
// presented combinationally and forced to zero while empty so the response
// data port reads 0 out of reset. The upstream credit scheme guarantees a
// free slot for every push; the full check only protects the storage.
module rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Pointer and occupancy bookkeeping; pops on an empty FIFO are ignored.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Control registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign valid = (count_q != '0);
  assign dout  = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/mont_reduce_arbiter.sv
// Two-port round-robin front end for a shared Montgomery reducer. Each
// request is tagged with its requester id, the tag follows the reducer
// pipeline, and the result lands in that requester's response FIFO. A
// requester may only issue while it holds a credit, and credits come back
// only when a response is popped, so a result never finds its FIFO full.
module mont_reduce_arbiter
  import kyber_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_a1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [15:0] rsp_t0,
  output logic [15:0] rsp_t1,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]     credit_q [2];
  logic [CW-1:0]     credit_d [2];
  logic              rr_q, rr_d;
  tag_t              tag_q [LAT];
  tag_t              tag_d [LAT];

  logic [1:0]        elig;
  logic [1:0]        gnt;
  logic [1:0]        pop;
  logic [1:0]        push;
  logic              red_set;
  logic [PROD_W-1:0] red_a;
  logic [COEF_W-1:0] red_t;
  logic [COEF_W-1:0] fifo_dout [2];
  logic              tag_any;

  // Arbitration: a lone eligible requester wins; on a tie rr decides.
  // Credits are the registered values, so a same-cycle pop cannot revive
  // a requester that is out of credit. Nothing is granted during reset.
  always_comb begin
    elig = '0;
    gnt  = '0;
    rr_d = rr_q;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid[i] && (credit_q[i] != '0);
    end
    if (!reset) begin
      case (elig)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
    // rr names the requester that wins the next tie: the one just passed over.
    if (gnt != 2'b00) begin
      rr_d = gnt[0];
    end
    red_set = |gnt;
    red_a   = gnt[1] ? req_a1 : req_a0;
  end

  assign req_ready = gnt;

  // Credit accounting: a grant spends one, a pop returns one.
  always_comb begin
    pop = rsp_valid & rsp_ready;
    for (int i = 0; i < 2; i++) begin
      credit_d[i] = credit_q[i] - CW'(gnt[i]) + CW'(pop[i]);
    end
  end

  // Tag pipe matching the reducer latency; the last stage steers the push.
  always_comb begin
    tag_d[0].vld = |gnt;
    tag_d[0].id  = gnt[1];
    for (int j = 1; j < LAT; j++) begin
      tag_d[j] = tag_q[j-1];
    end
    push[0] = tag_q[LAT-1].vld && !tag_q[LAT-1].id;
    push[1] = tag_q[LAT-1].vld &&  tag_q[LAT-1].id;
    tag_any = 1'b0;
    for (int j = 0; j < LAT; j++) begin
      tag_any = tag_any | tag_q[j].vld;
    end
  end

  // State registers. Reset drops every in-flight tag, so results still in
  // the reducer are never written, and refills the credits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        credit_q[i] <= CW'(DEPTH);
      end
      rr_q <= 1'b0;
      for (int j = 0; j < LAT; j++) begin
        tag_q[j] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        credit_q[i] <= credit_d[i];
      end
      rr_q <= rr_d;
      for (int j = 0; j < LAT; j++) begin
        tag_q[j] <= tag_d[j];
      end
    end
  end

  montgomery_reduce #(
    .LAT(LAT)
  ) u_reduce (
    .clk  (clk),
    .reset(reset),
    .set  (red_set),
    .a    (red_a),
    .t    (red_t)
  );

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      rsp_fifo #(
        .DEPTH(DEPTH),
        .W    (COEF_W)
      ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push[gi]),
        .din  (red_t),
        .pop  (rsp_ready[gi]),
        .valid(rsp_valid[gi]),
        .dout (fifo_dout[gi])
      );
    end
  endgenerate

  assign rsp_t0 = fifo_dout[0];
  assign rsp_t1 = fifo_dout[1];
  assign busy   = tag_any | (|rsp_valid);

endmodule

// File: tb/tb_mont_reduce_arbiter.sv
// Scoreboard bench for mont_reduce_arbiter: accepted requests push their
// hand-computed result into a per-requester queue; a response monitor pops
// and compares whenever a response is consumed.
module tb_mont_reduce_arbiter;

  localparam int LAT   = 1;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = '0;
  logic [31:0] req_a1 = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [15:0] rsp_t0, rsp_t1;
  logic        busy;

  mont_reduce_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a0   (req_a0),
    .req_a1   (req_a1),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_t0   (rsp_t0),
    .rsp_t1   (rsp_t1),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    int          t;
  } stim_t;

  stim_t pend0[$];
  stim_t pend1[$];
  int    exp0[$];
  int    exp1[$];
  int    gnt_log[$];
  int    acc[2];
  int    pops[2];
  int    out_cnt[2];
  logic [1:0] en = 2'b00;
  int    checks = 0;
  int    errors = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic stim_t mk(input logic [31:0] a, input int t);
    stim_t s;
    s.a = a;
    s.t = t;
    return s;
  endfunction

  // Drive request inputs from the pending stimulus queues.
  function automatic void refresh();
    if (reset) begin
      req_valid = 2'b11;
    end else begin
      req_valid[0] = en[0] && (pend0.size() > 0);
      req_valid[1] = en[1] && (pend1.size() > 0);
    end
    req_a0 = '0;
    req_a1 = '0;
    if (pend0.size() > 0) req_a0 = pend0[0].a;
    if (pend1.size() > 0) req_a1 = pend1[0].a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    refresh();
  endtask

  // Acceptance monitor: a request seen ready at the negedge is taken at
  // the following posedge; its expected result joins the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      exp0.delete();
      exp1.delete();
      out_cnt[0] = 0;
      out_cnt[1] = 0;
    end else begin
      chk("req_ready_onehot", int'($countones(req_ready) <= 1), 1);
      if (req_ready[0]) begin
        if (pend0.size() == 0) chk("req0_unexpected_ready", 1, 0);
        else begin
          exp0.push_back(pend0[0].t);
          void'(pend0.pop_front());
          acc[0]++;
          out_cnt[0]++;
          gnt_log.push_back(0);
        end
      end
      if (req_ready[1]) begin
        if (pend1.size() == 0) chk("req1_unexpected_ready", 1, 0);
        else begin
          exp1.push_back(pend1[0].t);
          void'(pend1.pop_front());
          acc[1]++;
          out_cnt[1]++;
          gnt_log.push_back(1);
        end
      end
    end
  end

  // Response monitor: compare each consumed response with the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid[0] && rsp_ready[0]) begin
        pops[0]++;
        out_cnt[0]--;
        if (exp0.size() == 0) chk("rsp0_unexpected", 1, 0);
        else chk("rsp0_value", int'($signed(rsp_t0)), exp0.pop_front());
      end
      if (rsp_valid[1] && rsp_ready[1]) begin
        pops[1]++;
        out_cnt[1]--;
        if (exp1.size() == 0) chk("rsp1_unexpected", 1, 0);
        else chk("rsp1_value", int'($signed(rsp_t1)), exp1.pop_front());
      end
      for (int i = 0; i < 2; i++) begin
        if (out_cnt[i] > DEPTH) chk("fifo_overflow", out_cnt[i], DEPTH);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    en    = 2'b00;
    refresh();
    tick();
    tick();
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_t0", int'(rsp_t0), 0);
    chk("rst_rsp_t1", int'(rsp_t1), 0);
    gnt_log.delete();
    reset = 1'b0;
    refresh();
  endtask

  task automatic drain();
    int n;
    n = 0;
    en = 2'b11;
    rsp_ready = 2'b11;
    refresh();
    while ((exp0.size() + exp1.size() + pend0.size() + pend1.size() > 0) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_done", int'(n < 200), 1);
    chk("drain_idle_busy", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, b0, b1, viol, hi;

    do_reset();

    // Single op on requester 0: a = 1 -> 169, first visible LAT edges
    // after the accepting edge.
    rsp_ready = 2'b00;
    pend0.push_back(mk(32'd1, 169));
    en = 2'b01;
    refresh();
    tick();
    chk("single_accepted", acc[0], 1);
    chk("single_not_early", int'(rsp_valid[0]), 0);
    cyc = 0;
    while (!rsp_valid[0] && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("single_latency_edges", cyc, LAT);
    chk("single_head", int'($signed(rsp_t0)), 169);
    drain();

    // Value set on requester 1.
    b1 = pops[1];
    pend1.push_back(mk(32'd0, 0));
    pend1.push_back(mk(32'd65536, 1));
    pend1.push_back(mk(32'hFFFF_FFFF, -169));
    pend1.push_back(mk(32'd1, 169));
    en = 2'b10;
    rsp_ready = 2'b11;
    refresh();
    drain();
    chk("values_count", pops[1] - b1, 4);

    // Contention from reset: grants alternate starting with requester 0.
    do_reset();
    pend0.push_back(mk(32'd1, 169));
    pend0.push_back(mk(32'd65536, 1));
    pend1.push_back(mk(32'hFFFF_FFFF, -169));
    pend1.push_back(mk(32'd0, 0));
    en = 2'b11;
    rsp_ready = 2'b11;
    refresh();
    for (int k = 0; k < 4; k++) tick();
    chk("contend_grants", gnt_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < gnt_log.size()) chk("contend_order", gnt_log[k], k % 2);
    end
    drain();

    // Credit stall: requester 0 never pops and runs out after DEPTH grants.
    for (int k = 0; k < 4; k++) pend0.push_back(mk(32'd1, 169));
    for (int k = 0; k < 2; k++) begin
      pend1.push_back(mk(32'd65536, 1));
      pend1.push_back(mk(32'd1, 169));
      pend1.push_back(mk(32'hFFFF_FFFF, -169));
    end
    b0 = acc[0];
    b1 = acc[1];
    en = 2'b11;
    rsp_ready = 2'b10;
    refresh();
    viol = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if ((acc[0] - b0 >= DEPTH) && req_ready[0]) viol++;
    end
    chk("stall_r0_grants", acc[0] - b0, DEPTH);
    chk("stall_r0_ready_low", viol, 0);
    chk("stall_r1_served", int'(acc[1] - b1 >= 3), 1);

    // One pop restores exactly one credit, usable on the next cycle.
    en = 2'b01;
    refresh();
    b0 = acc[0];
    rsp_ready = 2'b11;
    tick();
    rsp_ready = 2'b10;
    chk("pop_cycle_no_grant", acc[0] - b0, 0);
    tick();
    chk("pop_one_grant", acc[0] - b0, 1);
    for (int k = 0; k < 3; k++) tick();
    chk("pop_only_one_grant", acc[0] - b0, 1);
    drain();

    // Reset mid-flight: leaves rr pointing at requester 1 before reset.
    b0 = acc[0];
    pend0.push_back(mk(32'd1, 169));
    en = 2'b01;
    rsp_ready = 2'b11;
    refresh();
    tick();
    chk("midrst_accepted", acc[0] - b0, 1);
    reset = 1'b1;
    en = 2'b00;
    refresh();
    tick();
    reset = 1'b0;
    refresh();
    hi = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (rsp_valid != 2'b00) hi++;
    end
    chk("midrst_no_rsp", hi, 0);
    chk("midrst_busy", int'(busy), 0);

    gnt_log.delete();
    for (int k = 0; k < 3; k++) begin
      pend0.push_back(mk(32'd65536, 1));
      pend1.push_back(mk(32'd1, 169));
    end
    b0 = acc[0];
    b1 = acc[1];
    rsp_ready = 2'b00;
    en = 2'b11;
    refresh();
    for (int k = 0; k < 6; k++) tick();
    chk("midrst_first_grant", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
    chk("midrst_r0_credits", acc[0] - b0, DEPTH);
    chk("midrst_r1_credits", acc[1] - b1, DEPTH);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
